hist_eq_stream: RTL and testbench

//   Sequential, parametrised histogram equaliser for the decoded-image path.

---
 rtl/hist_eq_stream_if.sv | 23 ++
 rtl/hist_eq_stream.sv | 228 ++++++++++++++++++++++
 tb/tb_hist_eq_stream.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hist_eq_stream_if.sv
// hist_eq_stream_if: pixel-in / pixel-out valid-ready bundle for hist_eq_stream.
// master = upstream/downstream side (drives pixels in, takes pixels out),
// slave  = the equaliser itself.
interface hist_eq_stream_if #(
   parameter int PIX_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [PIX_W-1:0] in_pixel;
   logic             out_valid;
   logic             out_ready;
   logic [PIX_W-1:0] out_pixel;

   modport master (
      output in_valid, in_pixel, out_ready,
      input  in_ready, out_valid, out_pixel
   );

   modport slave (
      input  in_valid, in_pixel, out_ready,
      output in_ready, out_valid, out_pixel
   );
endinterface

// File: rtl/hist_eq_stream.sv
// hist_eq_stream: two-pass streaming histogram equaliser.
// Pass 1 builds a histogram, an internal scan turns it into a CDF (in place)
// and then into a rounded remap LUT, pass 2 remaps the same frame.
// Optional feature: define HIST_EQ_CLIP_EN to clip every bin at CLIP_LIMIT
// before accumulation; without it there is no clip logic at all.
module hist_eq_stream #(
   parameter int PIX_W      = 8,
   parameter int NPIX       = 76800,
   parameter int CNT_W      = 17,
   parameter int CLIP_LIMIT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic busy,
   output logic done,
   hist_eq_stream_if.slave px
);
   localparam int BINS  = 1 << PIX_W;
   localparam int MAXV  = BINS - 1;
   localparam int MUL_W = CNT_W + PIX_W + 2;
   localparam logic [PIX_W:0]   IDX_LAST = (PIX_W+1)'(MAXV);
   localparam logic [PIX_W:0]   IDX_END  = (PIX_W+1)'(BINS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPIX - 1);
   localparam logic [CNT_W-1:0] CNT_NPIX = CNT_W'(NPIX);

   // Counters must hold a whole frame; a clip ceiling below 1 is meaningless.
   if ((longint'(1) << CNT_W) <= longint'(NPIX) || CLIP_LIMIT < 1) begin : g_param_check
      $error("hist_eq_stream: CNT_W too narrow for NPIX, or CLIP_LIMIT < 1");
   end

   typedef enum logic [2:0] {IDLE, CLEAR, HIST, SCAN, LUT, APPLY} state_t;
   // Operation carried by the one-cycle RAM read pipeline stage.
   typedef enum logic [1:0] {OP_NONE, OP_HINC, OP_SCAN, OP_LUT} op_t;

   state_t state, state_next;
   logic [PIX_W:0]   idx;
   logic [CNT_W-1:0] in_cnt, out_cnt;
   logic             in_hs, out_hs;

   // Histogram RAM, overwritten in place by the CDF during SCAN.
   logic [CNT_W-1:0] hist_mem [BINS];
   logic [PIX_W-1:0] lut_mem  [BINS];
   logic [PIX_W-1:0] rd_addr;
   logic [CNT_W-1:0] rd_data;

   op_t              s1_op;
   logic [PIX_W-1:0] s1_bin;
   logic             wr_valid;
   logic [PIX_W-1:0] wr_bin;
   logic [CNT_W-1:0] wr_data;
   logic             hist_we;
   logic [PIX_W-1:0] hist_wa;
   logic [CNT_W-1:0] hist_wd;

   logic [CNT_W-1:0] cur, add, sum, sum_next, cdf_min, total, num, den;
   logic             found;
   logic [MUL_W-1:0] numer, divisor, quot;
   logic [PIX_W-1:0] lut_val;

   assign in_hs  = px.in_valid & px.in_ready;
   assign out_hs = px.out_valid & px.out_ready;
   assign busy   = (state != IDLE);
   assign done   = (state == APPLY) && out_hs && (out_cnt == CNT_LAST);

   // Accept pixels only in the two streaming passes; APPLY stalls on a full output register.
   always_comb begin
      px.in_ready = 1'b0;
      if (state == HIST)
         px.in_ready = 1'b1;
      else if (state == APPLY)
         px.in_ready = (in_cnt < CNT_NPIX) && (!px.out_valid || px.out_ready);
   end

   // Next-state logic; CLEAR and SCAN walk every bin, LUT adds one drain cycle.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = CLEAR;
         CLEAR:   if (idx == IDX_LAST) state_next = HIST;
         HIST:    if (in_hs && in_cnt == CNT_LAST) state_next = SCAN;
         SCAN:    if (idx == IDX_LAST) state_next = LUT;
         LUT:     if (idx == IDX_END) state_next = APPLY;
         APPLY:   if (done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Bin index and pixel handshake counters, restarted on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         in_cnt  <= '0;
         out_cnt <= '0;
      end else begin
         if ((state == CLEAR || state == SCAN || state == LUT) && state_next == state)
            idx <= idx + 1'b1;
         else
            idx <= '0;
         if (state_next != state) in_cnt <= '0;
         else if (in_hs)          in_cnt <= in_cnt + 1'b1;
         if (state != APPLY)      out_cnt <= '0;
         else if (out_hs)         out_cnt <= out_cnt + 1'b1;
      end
   end

   assign rd_addr = (state == HIST) ? px.in_pixel : idx[PIX_W-1:0];

   // Read pipeline stage: tags the word arriving from the RAM next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_op  <= OP_NONE;
         s1_bin <= '0;
      end else begin
         s1_bin <= rd_addr;
         if (state == HIST && in_hs)            s1_op <= OP_HINC;
         else if (state == SCAN)                s1_op <= OP_SCAN;
         else if (state == LUT && idx <= IDX_LAST) s1_op <= OP_LUT;
         else                                   s1_op <= OP_NONE;
      end
   end

   // Histogram RAM registered read.
   always_ff @(posedge clk) begin
      rd_data <= hist_mem[rd_addr];
   end

   // The read issued alongside last cycle's write missed it, so forward that write.
   assign cur = (wr_valid && wr_bin == s1_bin) ? wr_data : rd_data;

`ifdef HIST_EQ_CLIP_EN
   assign add = (cur > CNT_W'(CLIP_LIMIT)) ? CNT_W'(CLIP_LIMIT) : cur;
`else
   assign add = cur;
`endif
   assign sum_next = sum + add;

   // Single histogram write port: clear, increment, or CDF write-back.
   always_comb begin
      hist_we = 1'b0;
      hist_wa = s1_bin;
      hist_wd = '0;
      if (state == CLEAR) begin
         hist_we = 1'b1;
         hist_wa = idx[PIX_W-1:0];
      end else if (s1_op == OP_HINC) begin
         hist_we = 1'b1;
         hist_wd = cur + 1'b1;
      end else if (s1_op == OP_SCAN) begin
         hist_we = 1'b1;
         hist_wd = sum_next;
      end
   end

   // Histogram RAM write.
   always_ff @(posedge clk) begin
      if (hist_we) hist_mem[hist_wa] <= hist_wd;
   end

   // Remember the last write for forwarding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_valid <= 1'b0;
         wr_bin   <= '0;
         wr_data  <= '0;
      end else begin
         wr_valid <= hist_we;
         wr_bin   <= hist_wa;
         wr_data  <= hist_wd;
      end
   end

   // CDF accumulation, first nonzero bin capture and final total.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum     <= '0;
         found   <= 1'b0;
         cdf_min <= '0;
         total   <= '0;
      end else if (state == CLEAR) begin
         sum   <= '0;
         found <= 1'b0;
      end else if (s1_op == OP_SCAN) begin
         sum   <= sum_next;
         total <= sum_next;
         if (!found && add != '0) begin
            found   <= 1'b1;
            cdf_min <= sum_next;
         end
      end
   end

   // Rounded remap value for the bin in the pipeline stage; identity for a flat frame.
   always_comb begin
      num     = (cur >= cdf_min) ? cur - cdf_min : '0;
      den     = total - cdf_min;
      numer   = ((MUL_W'(num) * MUL_W'(MAXV)) << 1) + MUL_W'(den);
      divisor = (den == '0) ? MUL_W'(1) : (MUL_W'(den) << 1);
      quot    = numer / divisor;
      if (den == '0)                   lut_val = s1_bin;
      else if (quot > MUL_W'(MAXV))    lut_val = PIX_W'(MAXV);
      else                             lut_val = quot[PIX_W-1:0];
   end

   // LUT RAM write.
   always_ff @(posedge clk) begin
      if (s1_op == OP_LUT) lut_mem[s1_bin] <= lut_val;
   end

   // Output register: loaded from the LUT on an APPLY handshake, held until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px.out_valid <= 1'b0;
         px.out_pixel <= '0;
      end else if (state == APPLY && in_hs) begin
         px.out_valid <= 1'b1;
         px.out_pixel <= lut_mem[px.in_pixel];
      end else if (out_hs) begin
         px.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_hist_eq_stream.sv
// tb_hist_eq_stream: table-driven frames plus a reset-abort sequence and random
// frames checked against a reference LUT; outputs go through a scoreboard queue.
// dut_a: NPIX=4, dut_b: NPIX=8 with CLIP_LIMIT=2 (clip active with HIST_EQ_CLIP_EN).
module tb_hist_eq_stream;
   typedef logic [0:7][7:0] pix8_t;
   typedef struct {
      bit    s;
      int    n;
      pix8_t hp;
      pix8_t ap;
      pix8_t ex;
      int    mode;
      bit    mid;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sel = 1'b0;
   logic start = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   logic [7:0] in_pixel = 8'd0;
   logic busy_a, busy_b, done_a, done_b, start_a, start_b;
   logic busy_m, done_m, in_ready_m, out_valid_m;
   logic [7:0] out_pixel_m;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   hist_eq_stream_if #(.PIX_W(8)) if_a ();
   hist_eq_stream_if #(.PIX_W(8)) if_b ();

   assign start_a        = start & ~sel;
   assign start_b        = start & sel;
   assign if_a.in_valid  = in_valid & ~sel;
   assign if_b.in_valid  = in_valid & sel;
   assign if_a.in_pixel  = in_pixel;
   assign if_b.in_pixel  = in_pixel;
   assign if_a.out_ready = out_ready;
   assign if_b.out_ready = out_ready;
   assign busy_m      = sel ? busy_b : busy_a;
   assign done_m      = sel ? done_b : done_a;
   assign in_ready_m  = sel ? if_b.in_ready : if_a.in_ready;
   assign out_valid_m = sel ? if_b.out_valid : if_a.out_valid;
   assign out_pixel_m = sel ? if_b.out_pixel : if_a.out_pixel;

   hist_eq_stream #(.PIX_W(8), .NPIX(4), .CNT_W(17), .CLIP_LIMIT(64)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .px(if_a)
   );
   hist_eq_stream #(.PIX_W(8), .NPIX(8), .CNT_W(17), .CLIP_LIMIT(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .px(if_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Independent reference: histogram -> (clipped) CDF -> rounded LUT entry for pixel b.
   function automatic logic [7:0] model_lut(input pix8_t hp, input int n, input int limit,
                                            input logic [7:0] b);
      longint tot, cmin, cdf_b, den, num, q;
      int cnt;
      bit found;
      tot = 0; cmin = 0; cdf_b = 0; found = 0;
      for (int v = 0; v < 256; v++) begin
         cnt = 0;
         for (int k = 0; k < n; k++) if (hp[k] == 8'(v)) cnt++;
         if (limit > 0 && cnt > limit) cnt = limit;
         tot += cnt;
         if (!found && cnt > 0) begin found = 1; cmin = tot; end
         if (8'(v) == b) cdf_b = tot;
      end
      den = tot - cmin;
      if (den == 0) return b;
      num = (cdf_b > cmin) ? cdf_b - cmin : 0;
      q = (2 * num * 255 + den) / (2 * den);
      if (q > 255) q = 255;
      return 8'(q);
   endfunction

   task automatic run_frame(input vec_t v, input string tag);
      int sent, got, cyc;
      logic [7:0] held, e;
      bit hold_chk;
      sel = v.s;
      out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      check({tag, " busy_after_start"}, busy_m, 1);
      // Histogram pass
      sent = 0; cyc = 0;
      while (sent < v.n && cyc < 2000) begin
         in_valid = 1'b1;
         in_pixel = v.hp[sent];
         start = v.mid && (sent == 2);
         #1;
         if (in_ready_m) sent++;
         step();
         cyc++;
      end
      start = 1'b0;
      in_valid = 1'b0;
      check({tag, " hist_pixels_accepted"}, sent, v.n);
      // Wait through SCAN/LUT
      cyc = 0;
      #1;
      while (!in_ready_m && cyc < 2000) begin
         step();
         #1;
         cyc++;
      end
      @(negedge clk);
      // Apply pass
      sent = 0; got = 0; cyc = 0; hold_chk = 0; held = 8'd0;
      while (got < v.n && cyc < 3000) begin
         in_valid = (sent < v.n);
         if (sent < v.n) in_pixel = v.ap[sent];
         case (v.mode)
            1:       out_ready = (cyc >= 4 && cyc < 7) ? 1'b0 : (cyc % 2 == 0);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
         endcase
         #1;
         if (hold_chk) begin
            check({tag, " valid_held"}, out_valid_m, 1);
            check({tag, " pixel_held"}, out_pixel_m, held);
         end
         if (out_valid_m && out_ready) begin
            if (exp_q.size() == 0) begin
               check({tag, " unexpected_output"}, exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("%s out[%0d]", tag, got), out_pixel_m, e);
            end
            got++;
            check($sformatf("%s done[%0d]", tag, got), done_m, (got == v.n));
         end else if (done_m) begin
            check({tag, " done_spurious"}, done_m, 0);
         end
         if (in_valid && in_ready_m) begin
            exp_q.push_back(v.ex[sent]);
            sent++;
         end
         hold_chk = out_valid_m && !out_ready;
         held = out_pixel_m;
         step();
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      check({tag, " outputs_seen"}, got, v.n);
      check({tag, " busy_at_end"}, busy_m, 0);
      check({tag, " scoreboard_empty"}, exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
   endtask

   vec_t vecs[5];
   vec_t rv;
   int lim;
   int sent, cyc;

   initial begin
`ifdef HIST_EQ_CLIP_EN
      lim = 2;
`else
      lim = 0;
`endif
      vecs[0] = '{s:0, n:4, hp:{8'd10, 8'd10, 8'd20, 8'd30, 32'd0},
                  ap:{8'd10, 8'd20, 8'd30, 8'd10, 32'd0},
                  ex:{8'd0, 8'd128, 8'd255, 8'd0, 32'd0}, mode:0, mid:0};
      vecs[1] = '{s:0, n:4, hp:{8'd7, 8'd7, 8'd7, 8'd7, 32'd0},
                  ap:{8'd7, 8'd7, 8'd7, 8'd7, 32'd0},
                  ex:{8'd7, 8'd7, 8'd7, 8'd7, 32'd0}, mode:0, mid:0};
      vecs[2] = vecs[0];
      vecs[2].mode = 1;
      vecs[3] = '{s:1, n:8, hp:{8'd0, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd9, 8'd9},
                  ap:{8'd0, 8'd5, 8'd9, 8'd5, 8'd0, 8'd9, 8'd9, 8'd5},
`ifdef HIST_EQ_CLIP_EN
                  ex:{8'd0, 8'd128, 8'd255, 8'd128, 8'd0, 8'd255, 8'd255, 8'd128},
`else
                  ex:{8'd0, 8'd182, 8'd255, 8'd182, 8'd0, 8'd255, 8'd255, 8'd182},
`endif
                  mode:0, mid:0};
      vecs[4] = '{s:0, n:4, hp:{8'd4, 8'd2, 8'd3, 8'd1, 32'd0},
                  ap:{8'd1, 8'd2, 8'd255, 8'd0, 32'd0},
                  ex:{8'd0, 8'd85, 8'd255, 8'd0, 32'd0}, mode:2, mid:0};

      // Reset state of both instances
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         check($sformatf("reset[%0d] busy", s), busy_m, 0);
         check($sformatf("reset[%0d] in_ready", s), in_ready_m, 0);
         check($sformatf("reset[%0d] out_valid", s), out_valid_m, 0);
         check($sformatf("reset[%0d] out_pixel", s), out_pixel_m, 0);
         check($sformatf("reset[%0d] done", s), done_m, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

      // Abort by reset after two histogram pixels, then a clean rerun
      sel = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      sent = 0; cyc = 0;
      while (sent < 2 && cyc < 2000) begin
         in_valid = 1'b1;
         in_pixel = 8'd30;
         #1;
         if (in_ready_m) sent++;
         step();
         cyc++;
      end
      in_valid = 1'b0;
      check("abort hist_pixels_accepted", sent, 2);
      rst_n = 1'b0;
      #1;
      check("abort busy", busy_m, 0);
      check("abort in_ready", in_ready_m, 0);
      check("abort out_valid", out_valid_m, 0);
      check("abort out_pixel", out_pixel_m, 0);
      step();
      check("abort busy_next_edge", busy_m, 0);
      rst_n = 1'b1;
      @(negedge clk);
      run_frame(vecs[0], "rerun");

      // Random frames on the 8-pixel instance, start pulsed mid-run
      for (int f = 0; f < 12; f++) begin
         rv.s = 1; rv.n = 8; rv.mode = 2; rv.mid = 1;
         for (int k = 0; k < 8; k++) begin
            rv.hp[k] = (f % 2 == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            rv.ap[k] = (k < 4) ? rv.hp[$urandom_range(0, 7)] : 8'($urandom_range(0, 255));
         end
         for (int k = 0; k < 8; k++) rv.ex[k] = model_lut(rv.hp, 8, lim, rv.ap[k]);
         run_frame(rv, $sformatf("rand%0d", f));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
